// File: rtl/encoder8_3_evt_if.sv
// Request lines, capture enable and code handshake for the
// event-capturing 8-to-3 encoder.
interface encoder8_3_evt_if;
  logic en;
  logic D0, D1, D2, D3;
  logic D4, D5, D6, D7;
  logic A, B, C;
  logic valid;
  logic ready;
  logic pend_any;
  logic ovf;

  modport master (
    input  en,
    input  D0, D1, D2, D3,
    input  D4, D5, D6, D7,
    input  ready,
    output A, B, C,
    output valid,
    output pend_any,
    output ovf
  );

  modport slave (
    output en,
    output D0, D1, D2, D3,
    output D4, D5, D6, D7,
    output ready,
    input  A, B, C,
    input  valid,
    input  pend_any,
    input  ovf
  );
endinterface

// File: rtl/encoder8_3_evt.sv
// Event-capturing 8-to-3 encoder: latches rising edges on D0..D7
// and serializes them as 3-bit codes over a valid/ready handshake.
module encoder8_3_evt #(
  parameter bit PRI_HIGH = 1'b1
) (
  input logic             clk,
  input logic             rst,
  encoder8_3_evt_if.master bus
);

  logic [7:0] d_i;
  logic [7:0] d_prev_q;
  logic [7:0] pend_q, pend_d;
  logic [7:0] rise, clr;
  logic [2:0] code_q, code_d;
  logic [2:0] pick;
  logic       valid_q, valid_d;
  logic       ovf_q, ovf_d;
  logic       load;

  assign d_i = {bus.D7, bus.D6, bus.D5, bus.D4,
                bus.D3, bus.D2, bus.D1, bus.D0};

  assign rise = d_i & ~d_prev_q & {8{bus.en}};

  // Later loop hits overwrite earlier ones, so scan toward the winner.
  always_comb begin
    pick = '0;
    if (PRI_HIGH) begin
      for (int i = 0; i < 8; i++)
        if (pend_q[i]) pick = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (pend_q[i]) pick = 3'(i);
    end
  end

  assign load = (~valid_q | bus.ready) & (|pend_q);
  assign clr  = load ? (8'b1 << pick) : 8'b0;

  always_comb begin
    pend_d  = rise | (pend_q & ~clr);
    ovf_d   = ovf_q | (|(rise & pend_q & ~clr));
    code_d  = code_q;
    valid_d = valid_q;
    if (load) begin
      code_d  = pick;
      valid_d = 1'b1;
    end else if (valid_q & bus.ready) begin
      valid_d = 1'b0;
    end
  end

  // Sampling D during reset keeps lines held high from firing later.
  always_ff @(posedge clk) begin
    d_prev_q <= d_i;
    if (rst) begin
      pend_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.A        = code_q[2];
  assign bus.B        = code_q[1];
  assign bus.C        = code_q[0];
  assign bus.valid    = valid_q;
  assign bus.pend_any = |pend_q;
  assign bus.ovf      = ovf_q;

endmodule
